// File: rtl/data_phy.sv
// SD DAT-line serial PHY: frames one 32-bit word with a CRC16-CCITT trailer
// in either direction on a single data pin, one bit per SD_clock cycle.
module data_phy (
    input  logic        SD_clock,
    input  logic        Reset,
    input  logic        Send,
    input  logic        Idle,
    input  logic        WriteRead,
    input  logic [31:0] Data_from_FIFO,
    input  logic [15:0] Timeout_reg,
    input  logic        Data_pin_in,
    output logic        Data_pin_out,
    output logic        Data_oe,
    output logic        Serial_ready,
    output logic        Complete,
    output logic [31:0] Data_to_FIFO,
    output logic        CRC_error,
    output logic        Timeout
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        READY   = 4'd1,
        TX_DATA = 4'd2,
        TX_CRC  = 4'd3,
        TX_END  = 4'd4,
        RX_WAIT = 4'd5,
        RX_DATA = 4'd6,
        RX_CRC  = 4'd7,
        RX_END  = 4'd8,
        DONE    = 4'd9
    } state_t;

    state_t      state_r;
    logic [5:0]  bit_cnt_r;
    logic [15:0] wait_cnt_r;
    logic [31:0] shift_r;
    logic [15:0] crc_r;
    logic [15:0] rx_crc_r;
    logic        timeout_hit_s;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // Timeout decision: registered pulse lands in cycle Timeout_reg counted from the Send edge
    always_comb begin
        if (Timeout_reg != 16'd0) begin
            timeout_hit_s = (({1'b0, wait_cnt_r} + 17'd2) >= {1'b0, Timeout_reg});
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Frame sequencer with all outputs registered
    always_ff @(posedge SD_clock or negedge Reset) begin
        if (!Reset) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 6'd0;
            wait_cnt_r   <= 16'd0;
            shift_r      <= 32'd0;
            crc_r        <= 16'd0;
            rx_crc_r     <= 16'd0;
            Data_pin_out <= 1'b1;
            Data_oe      <= 1'b0;
            Serial_ready <= 1'b0;
            Complete     <= 1'b0;
            Timeout      <= 1'b0;
            Data_to_FIFO <= 32'd0;
            CRC_error    <= 1'b0;
        end else if (Idle) begin
            state_r      <= IDLE;
            bit_cnt_r    <= 6'd0;
            wait_cnt_r   <= 16'd0;
            shift_r      <= 32'd0;
            crc_r        <= 16'd0;
            rx_crc_r     <= 16'd0;
            Data_pin_out <= 1'b1;
            Data_oe      <= 1'b0;
            Serial_ready <= 1'b0;
            Complete     <= 1'b0;
            Timeout      <= 1'b0;
        end else begin
            Complete <= 1'b0;
            Timeout  <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r      <= READY;
                    bit_cnt_r    <= 6'd0;
                    wait_cnt_r   <= 16'd0;
                    Serial_ready <= 1'b1;
                end
                READY: begin
                    if (Send) begin
                        shift_r      <= Data_from_FIFO;
                        crc_r        <= 16'd0;
                        rx_crc_r     <= 16'd0;
                        bit_cnt_r    <= 6'd0;
                        wait_cnt_r   <= 16'd0;
                        Serial_ready <= 1'b0;
                        if (WriteRead) begin
                            state_r      <= TX_DATA;
                            Data_pin_out <= 1'b0;
                            Data_oe      <= 1'b1;
                        end else begin
                            state_r <= RX_WAIT;
                        end
                    end else begin
                        Serial_ready <= 1'b1;
                    end
                end
                TX_DATA: begin
                    Data_pin_out <= shift_r[31];
                    shift_r      <= {shift_r[30:0], 1'b0};
                    crc_r        <= crc16_step(crc_r, shift_r[31]);
                    if (bit_cnt_r == 6'd31) begin
                        state_r   <= TX_CRC;
                        bit_cnt_r <= 6'd0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                TX_CRC: begin
                    Data_pin_out <= crc_r[15];
                    crc_r        <= {crc_r[14:0], 1'b0};
                    if (bit_cnt_r == 6'd15) begin
                        state_r   <= TX_END;
                        bit_cnt_r <= 6'd0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                TX_END: begin
                    Data_pin_out <= 1'b1;
                    state_r      <= DONE;
                    bit_cnt_r    <= 6'd0;
                end
                RX_WAIT: begin
                    if (!Data_pin_in) begin
                        state_r    <= RX_DATA;
                        bit_cnt_r  <= 6'd0;
                        wait_cnt_r <= 16'd0;
                    end else if (timeout_hit_s) begin
                        state_r      <= READY;
                        Timeout      <= 1'b1;
                        Serial_ready <= 1'b1;
                        wait_cnt_r   <= 16'd0;
                    end else if (wait_cnt_r != 16'hFFFF) begin
                        wait_cnt_r <= wait_cnt_r + 16'd1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                RX_DATA: begin
                    shift_r <= {shift_r[30:0], Data_pin_in};
                    crc_r   <= crc16_step(crc_r, Data_pin_in);
                    if (bit_cnt_r == 6'd31) begin
                        state_r   <= RX_CRC;
                        bit_cnt_r <= 6'd0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                RX_CRC: begin
                    rx_crc_r <= {rx_crc_r[14:0], Data_pin_in};
                    if (bit_cnt_r == 6'd15) begin
                        state_r   <= RX_END;
                        bit_cnt_r <= 6'd0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                RX_END: begin
                    Data_to_FIFO <= shift_r;
                    CRC_error    <= (crc_r != rx_crc_r) | ~Data_pin_in;
                    Complete     <= 1'b1;
                    state_r      <= DONE;
                    bit_cnt_r    <= 6'd0;
                end
                DONE: begin
                    // Receive arrives here with Complete already raised; transmit raises it here
                    if (Complete) begin
                        state_r      <= READY;
                        Serial_ready <= 1'b1;
                    end else begin
                        Complete     <= 1'b1;
                        Data_oe      <= 1'b0;
                        Data_pin_out <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    Data_pin_out <= 1'b1;
                    Data_oe      <= 1'b0;
                    Serial_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_phy.sv
// Directed bench for data_phy: one transmitter and one receiver instance,
// optionally looped back through a bit-flip injector.
module tb_data_phy;

    logic        sd_clock_s;
    logic        reset_n_s;
    logic        tx_send_s, tx_idle_s, tx_wr_s, tx_din_s;
    logic [31:0] tx_word_s;
    logic [15:0] tx_to_s;
    logic        tx_pin_s, tx_oe_s, tx_ready_s, tx_cmp_s, tx_crc_err_s, tx_tmo_s;
    logic [31:0] tx_d2f_s;
    logic        rx_send_s, rx_idle_s, rx_wr_s, rx_din_s;
    logic [31:0] rx_word_s;
    logic [15:0] rx_to_s;
    logic        rx_pin_s, rx_oe_s, rx_ready_s, rx_cmp_s, rx_crc_err_s, rx_tmo_s;
    logic [31:0] rx_d2f_s;
    logic        loop_sel_s, inject_s, force_din_s;

    logic [127:0] cap_line_s, cap_oe_s, cap_tcmp_s, cap_trdy_s, cap_rcmp_s, cap_rtmo_s, cap_rrdy_s;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] word;
        int          inj;
        logic        exp_err;
    } vec_t;
    vec_t vecs [6];

    assign rx_din_s = loop_sel_s ? (tx_pin_s ^ inject_s) : force_din_s;

    initial sd_clock_s = 1'b0;
    always #5 sd_clock_s = ~sd_clock_s;

    data_phy u_tx (
        .SD_clock(sd_clock_s), .Reset(reset_n_s), .Send(tx_send_s), .Idle(tx_idle_s),
        .WriteRead(tx_wr_s), .Data_from_FIFO(tx_word_s), .Timeout_reg(tx_to_s),
        .Data_pin_in(tx_din_s), .Data_pin_out(tx_pin_s), .Data_oe(tx_oe_s),
        .Serial_ready(tx_ready_s), .Complete(tx_cmp_s), .Data_to_FIFO(tx_d2f_s),
        .CRC_error(tx_crc_err_s), .Timeout(tx_tmo_s)
    );

    data_phy u_rx (
        .SD_clock(sd_clock_s), .Reset(reset_n_s), .Send(rx_send_s), .Idle(rx_idle_s),
        .WriteRead(rx_wr_s), .Data_from_FIFO(rx_word_s), .Timeout_reg(rx_to_s),
        .Data_pin_in(rx_din_s), .Data_pin_out(rx_pin_s), .Data_oe(rx_oe_s),
        .Serial_ready(rx_ready_s), .Complete(rx_cmp_s), .Data_to_FIFO(rx_d2f_s),
        .CRC_error(rx_crc_err_s), .Timeout(rx_tmo_s)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [31:0] w);
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ w[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [127:0] span(input int lo, input int hi);
        logic [127:0] v;
        v = {128{1'b0}};
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Expected line level for cycles 0..55 around a transmit
    function automatic logic [127:0] ref_line(input logic [31:0] w);
        logic [127:0] l;
        logic [15:0]  c;
        c = ref_crc(w);
        l = span(0, 55);
        l[1] = 1'b0;
        for (int k = 2; k <= 33; k++) l[k] = w[33-k];
        for (int k = 34; k <= 49; k++) l[k] = c[49-k];
        return l;
    endfunction

    // One frame starting at a negedge with both instances in READY; index k = cycle k
    task automatic run_frame(input logic do_tx, input logic do_rx, input logic [31:0] word, input int inj);
        cap_line_s = '0; cap_oe_s = '0; cap_tcmp_s = '0; cap_trdy_s = '0; cap_rcmp_s = '0;
        tx_word_s = word;
        for (int k = 0; k <= 55; k++) begin
            cap_line_s[k] = tx_pin_s;
            cap_oe_s[k]   = tx_oe_s;
            cap_tcmp_s[k] = tx_cmp_s;
            cap_trdy_s[k] = tx_ready_s;
            cap_rcmp_s[k] = rx_cmp_s;
            tx_send_s = do_tx && (k == 0 || k == 10);
            rx_send_s = do_rx && (k == 0);
            inject_s  = (inj != 0) && (k == inj);
            @(negedge sd_clock_s);
        end
        tx_send_s = 1'b0; rx_send_s = 1'b0; inject_s = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_d2f;
        logic        exp_err;
        logic [31:0] w;
        logic [15:0] c;

        vecs[0] = '{32'hA5C3_0F96, 0,  1'b0};
        vecs[1] = '{32'hA5C3_0F96, 10, 1'b1};
        vecs[2] = '{32'hA5C3_0F96, 50, 1'b1};
        vecs[3] = '{32'h1234_5678, 0,  1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 40, 1'b1};
        vecs[5] = '{32'h0000_0001, 33, 1'b1};

        reset_n_s = 1'b0;
        tx_send_s = 1'b0; tx_idle_s = 1'b1; tx_wr_s = 1'b1; tx_din_s = 1'b1;
        tx_word_s = 32'd0; tx_to_s = 16'd0;
        rx_send_s = 1'b0; rx_idle_s = 1'b1; rx_wr_s = 1'b0;
        rx_word_s = 32'd0; rx_to_s = 16'd0;
        loop_sel_s = 1'b1; inject_s = 1'b0; force_din_s = 1'b1;

        repeat (3) @(negedge sd_clock_s);
        check("reset_tx_outputs", {tx_pin_s, tx_oe_s, tx_ready_s, tx_cmp_s, tx_tmo_s, tx_crc_err_s}, 6'b100000);
        check("reset_rx_outputs", {rx_pin_s, rx_oe_s, rx_ready_s, rx_cmp_s, rx_tmo_s, rx_crc_err_s}, 6'b100000);
        check("reset_rx_d2f", rx_d2f_s, 32'd0);

        reset_n_s = 1'b1;
        @(negedge sd_clock_s);
        check("idle_held_not_ready", {tx_ready_s, rx_ready_s}, 2'b00);
        tx_idle_s = 1'b0; rx_idle_s = 1'b0;
        @(negedge sd_clock_s);
        check("ready_after_idle_drop", {tx_ready_s, rx_ready_s}, 2'b11);

        // All-zero word: line low cycles 1..49, end bit 50, Complete in 51
        run_frame(1'b1, 1'b0, 32'd0, 0);
        check("zero_line", cap_line_s, ref_line(32'd0));
        check("zero_oe", cap_oe_s, span(1, 50));
        check("zero_complete", cap_tcmp_s, span(51, 51));
        check("zero_ready", cap_trdy_s & ~span(51, 51), span(0, 0) | span(52, 55));
        check("rx_no_complete_when_idle", cap_rcmp_s, 128'd0);

        // Loopback table
        for (int i = 0; i < 6; i++) begin
            run_frame(1'b1, 1'b1, vecs[i].word, vecs[i].inj);
            exp_d2f = vecs[i].word;
            if (vecs[i].inj >= 2 && vecs[i].inj <= 33) exp_d2f = exp_d2f ^ (32'd1 << (33 - vecs[i].inj));
            check("loop_rx_d2f", rx_d2f_s, exp_d2f);
            check("loop_rx_crc_err", rx_crc_err_s, vecs[i].exp_err);
            check("loop_rx_complete", cap_rcmp_s, span(51, 51));
            check("loop_tx_complete", cap_tcmp_s, span(51, 51));
            check("loop_tx_line", cap_line_s, ref_line(vecs[i].word));
        end
        exp_d2f = 32'h0000_0000;
        exp_err = 1'b1;

        // Receive timeout with the line held high
        loop_sel_s = 1'b0; force_din_s = 1'b1; rx_to_s = 16'd70;
        cap_rtmo_s = '0; cap_rcmp_s = '0; cap_rrdy_s = '0;
        for (int k = 0; k <= 75; k++) begin
            cap_rtmo_s[k] = rx_tmo_s;
            cap_rcmp_s[k] = rx_cmp_s;
            cap_rrdy_s[k] = rx_ready_s;
            rx_send_s = (k == 0);
            @(negedge sd_clock_s);
        end
        rx_send_s = 1'b0;
        check("timeout_pulse", cap_rtmo_s, span(70, 70));
        check("timeout_no_complete", cap_rcmp_s, 128'd0);
        check("timeout_ready", cap_rrdy_s & (span(1, 69) | span(71, 75)), span(71, 75));
        check("hold_d2f", rx_d2f_s, exp_d2f);
        check("hold_crc_err", rx_crc_err_s, exp_err);

        // Delayed start bit in cycle 6, driven directly
        w = 32'hDEAD_BEEF;
        c = ref_crc(w);
        cap_rtmo_s = '0; cap_rcmp_s = '0;
        for (int k = 0; k <= 60; k++) begin
            cap_rtmo_s[k] = rx_tmo_s;
            cap_rcmp_s[k] = rx_cmp_s;
            rx_send_s = (k == 0);
            if (k == 6)                  force_din_s = 1'b0;
            else if (k >= 7 && k <= 38)  force_din_s = w[38-k];
            else if (k >= 39 && k <= 54) force_din_s = c[54-k];
            else                         force_din_s = 1'b1;
            @(negedge sd_clock_s);
        end
        rx_send_s = 1'b0; force_din_s = 1'b1;
        check("late_start_d2f", rx_d2f_s, 32'hDEAD_BEEF);
        check("late_start_crc_err", rx_crc_err_s, 1'b0);
        check("late_start_complete", cap_rcmp_s, span(56, 56));
        check("late_start_no_timeout", cap_rtmo_s, 128'd0);

        // Idle during transmit at cycle 20, released at cycle 25
        cap_oe_s = '0; cap_tcmp_s = '0; cap_trdy_s = '0; cap_line_s = '0;
        tx_word_s = 32'hFFFF_FFFF;
        for (int k = 0; k <= 60; k++) begin
            cap_oe_s[k]   = tx_oe_s;
            cap_tcmp_s[k] = tx_cmp_s;
            cap_trdy_s[k] = tx_ready_s;
            cap_line_s[k] = tx_pin_s;
            tx_send_s = (k == 0);
            tx_idle_s = (k >= 20 && k <= 24);
            @(negedge sd_clock_s);
        end
        tx_send_s = 1'b0; tx_idle_s = 1'b0;
        check("idle_abort_oe", cap_oe_s, span(1, 20));
        check("idle_abort_no_complete", cap_tcmp_s, 128'd0);
        check("idle_abort_ready", cap_trdy_s & ~span(0, 0), span(26, 60));
        check("idle_abort_line_high", cap_line_s & span(21, 60), span(21, 60));

        // Idle and Send together in READY: Idle wins
        tx_idle_s = 1'b1; tx_send_s = 1'b1;
        @(negedge sd_clock_s);
        check("idle_wins_first", {tx_oe_s, tx_ready_s, tx_pin_s}, 3'b001);
        tx_send_s = 1'b0;
        repeat (3) @(negedge sd_clock_s);
        check("idle_wins_later", {tx_oe_s, tx_ready_s, tx_pin_s, tx_cmp_s}, 4'b0010);
        tx_idle_s = 1'b0;
        @(negedge sd_clock_s);
        check("idle_release_ready", tx_ready_s, 1'b1);

        // Reset mid-frame at cycle 10 of a loopback transfer
        loop_sel_s = 1'b1; rx_to_s = 16'd0;
        tx_word_s = 32'h5A5A_F00F;
        for (int k = 0; k <= 10; k++) begin
            tx_send_s = (k == 0);
            rx_send_s = (k == 0);
            if (k < 10) @(negedge sd_clock_s);
        end
        tx_send_s = 1'b0; rx_send_s = 1'b0;
        reset_n_s = 1'b0;
        #1;
        check("midreset_tx_outputs", {tx_pin_s, tx_oe_s, tx_ready_s, tx_cmp_s, tx_tmo_s, tx_crc_err_s}, 6'b100000);
        check("midreset_rx_outputs", {rx_ready_s, rx_cmp_s, rx_tmo_s, rx_crc_err_s, rx_d2f_s}, 36'd0);
        @(negedge sd_clock_s);
        reset_n_s = 1'b1;
        cap_tcmp_s = '0; cap_rcmp_s = '0;
        for (int k = 0; k <= 60; k++) begin
            cap_tcmp_s[k] = tx_cmp_s;
            cap_rcmp_s[k] = rx_cmp_s;
            @(negedge sd_clock_s);
        end
        check("midreset_no_complete", cap_tcmp_s | cap_rcmp_s, 128'd0);
        check("midreset_ready_after", {tx_ready_s, rx_ready_s, tx_oe_s}, 3'b110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_phy.md
DATA_PHY -- requirements
Module: data_phy

Interface
REQ-001 SHALL have port SD_clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Send  input  1  start a frame (direction per WriteRead); from DATA control block.
REQ-004 SHALL have port Idle  input  1  force PHY to IDLE/abort; from DATA control block.
REQ-005 SHALL have port WriteRead  input  1  1 = transmit to card, 0 = receive from card.
REQ-006 SHALL have port Data_from_FIFO  input  32  word to transmit.
REQ-007 SHALL have port Timeout_reg  input  16  receive start-bit wait limit in SD_clock cycles; 0 = no limit.
REQ-008 SHALL have port Data_pin_in  input  1  serial DAT line from card.
REQ-009 SHALL have port Data_pin_out  output  1  serial DAT line to card.
REQ-010 SHALL have port Data_oe  output  1  DAT output-enable; 1 while PHY drives the line.
REQ-011 SHALL have port Serial_ready  output  1  PHY in READY, accepting Send.
REQ-012 SHALL have port Complete  output  1  one-cycle pulse, frame finished.
REQ-013 SHALL have port Data_to_FIFO  output  32  received word.
REQ-014 SHALL have port CRC_error  output  1  receive CRC/end-bit mismatch; valid with Complete.
REQ-015 SHALL have port Timeout  output  1  one-cycle pulse, receive start bit not seen in time.

Function
REQ-016 Frame format SHALL be: start bit 0, 32 data bits MSB first, CRC16 MSB first, end bit 1 (50 bits, one per SD_clock cycle).
REQ-017 CRC SHALL be CRC16-CCITT, polynomial 0x1021, initial value 0x0000, computed over the 32 data bits only.
REQ-018 States SHALL be IDLE, READY, TX_DATA, TX_CRC, TX_END, RX_WAIT, RX_DATA, RX_CRC, RX_END, DONE.
REQ-019 IDLE -> READY on first cycle with Idle=0; Serial_ready=1 only in READY.
REQ-020 READY with Send=1 SHALL latch Data_from_FIFO and WriteRead, then go to TX_DATA (WriteRead=1) or RX_WAIT (WriteRead=0); Send outside READY SHALL be ignored.
REQ-021 Transmit: start bit SHALL be on Data_pin_out the cycle after Send is sampled; data in cycles 2-33, CRC in 34-49, end bit in 50; Data_oe=1 for cycles 1-50 only.
REQ-022 Transmit: DONE in cycle 51 SHALL pulse Complete=1 for one cycle, then READY.
REQ-023 Outside driving cycles Data_pin_out SHALL be 1 and Data_oe SHALL be 0.
REQ-024 RX_WAIT SHALL count cycles; first sampled Data_pin_in=0 is the start bit, next 32 bits shift into data, next 16 into received CRC, next bit is end bit.
REQ-025 RX_WAIT: if Timeout_reg!=0 and count reaches Timeout_reg with no start bit, Timeout SHALL pulse one cycle, no Complete, return to READY.
REQ-026 Receive: DONE SHALL present Data_to_FIFO, set CRC_error=1 if computed CRC != received CRC or end bit != 1, and pulse Complete one cycle, then READY.
REQ-027 Data_to_FIFO and CRC_error SHALL hold value until next receive Complete or reset.
REQ-028 Idle=1 in any state SHALL move to IDLE next cycle: Data_oe=0, Data_pin_out=1, no Complete/Timeout pulse, partial data discarded.
REQ-029 Idle and Send asserted in the same cycle: Idle SHALL win.
REQ-030 Bit counter SHALL be 6 bits, timeout counter 16 bits, both cleared on every state entry; no wrap-around within a frame.

Reset
REQ-031 Reset=0 SHALL immediately force IDLE, Data_pin_out=1, Data_oe=0, Serial_ready=0, Complete=0, Timeout=0, CRC_error=0, Data_to_FIFO=0, all counters and CRC register 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no Complete after release.

Verification
REQ-033 Reset release, Idle=0 -> Serial_ready=1 next cycle; WriteRead=1, Data_from_FIFO=0x00000000, Send pulse -> line 0 for 49 cycles, 1 in cycle 50, Data_oe high cycles 1-50, Complete in cycle 51.
REQ-034 Loopback: TX instance Data_pin_out to RX instance Data_pin_in, word 0xA5C3_0F96 -> RX Data_to_FIFO=0xA5C30F96, CRC_error=0, Complete once.
REQ-035 Loopback with one data bit inverted in flight -> CRC_error=1, Complete once; end bit forced 0 -> CRC_error=1.
REQ-036 WriteRead=0, Timeout_reg=70, Data_pin_in held 1 -> Timeout pulse at cycle 70 after Send, no Complete, Serial_ready=1 after.
REQ-037 Idle=1 at transmit cycle 20 -> Data_oe=0 next cycle, no Complete; Idle=0 -> READY; Reset low at cycle 10 -> all outputs at REQ-031 values immediately.
